// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges a never-stalled ALU port and a queued LSU port onto
// one register-file write port, with a forwarding lookup over pending writes.
module wb_arbiter #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        aluValid,
  input  logic [4:0]  aluReg,
  input  logic [31:0] aluData,
  input  logic        lsuValid,
  input  logic [4:0]  lsuReg,
  input  logic [31:0] lsuData,
  output logic        lsuReady,
  output logic        _regWrite,
  output logic [4:0]  writeReg,
  output logic [31:0] writeData,
  input  logic [4:0]  fwdReg,
  output logic        fwdHit,
  output logic [31:0] fwdData,
  output logic [3:0]  pendCount
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0] DEPTH_C = 4'(DEPTH);

  // Slots stay occupied after a kill until popped; q_live marks entries that
  // will still produce a write.
  logic [DEPTH-1:0] q_live;
  logic [4:0]       q_reg  [DEPTH];
  logic [31:0]      q_data [DEPTH];
  logic [AW-1:0]    head, tail, idx;
  logic [3:0]       entries;

  logic alu_req, occupied, pop, lsu_take, bypass, push;

  // Handshake: an LSU request transfers at a posedge where lsuValid && lsuReady;
  // lsuReady never depends on lsuValid, so there is no combinational loop.
  always_comb begin
    alu_req  = aluValid && (aluReg != 5'd0);
    occupied = (entries != 4'd0);
    pop      = !alu_req && occupied;
    lsuReady = (entries < DEPTH_C) || pop;
    lsu_take = lsuValid && lsuReady && (lsuReg != 5'd0)
               && !(alu_req && (aluReg == lsuReg));
    bypass   = lsu_take && !alu_req && !occupied;
    push     = lsu_take && !bypass;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      _regWrite <= 1'b0;
      writeReg  <= 5'd0;
      writeData <= 32'd0;
      q_live    <= '0;
      head      <= '0;
      tail      <= '0;
      entries   <= 4'd0;
      for (int i = 0; i < DEPTH; i++) begin
        q_reg[i]  <= 5'd0;
        q_data[i] <= 32'd0;
      end
    end else begin
      if (alu_req) begin
        _regWrite <= 1'b1;
        writeReg  <= aluReg;
        writeData <= aluData;
      end else if (pop) begin
        _regWrite <= q_live[head];
        writeReg  <= q_reg[head];
        writeData <= q_data[head];
      end else if (bypass) begin
        _regWrite <= 1'b1;
        writeReg  <= lsuReg;
        writeData <= lsuData;
      end else begin
        _regWrite <= 1'b0;
      end

      // Order matters: kill, then pop, then push, so a full-queue push into the
      // slot being popped this cycle ends up live.
      for (int i = 0; i < DEPTH; i++) begin
        if (alu_req && (q_reg[i] == aluReg)) q_live[i] <= 1'b0;
      end
      if (pop) begin
        q_live[head] <= 1'b0;
        head         <= head + 1'b1;
      end
      if (push) begin
        q_live[tail] <= 1'b1;
        q_reg[tail]  <= lsuReg;
        q_data[tail] <= lsuData;
        tail         <= tail + 1'b1;
      end
      entries <= entries + 4'(push) - 4'(pop);
    end
  end

  always_comb begin
    pendCount = 4'd0;
    for (int i = 0; i < DEPTH; i++) pendCount = pendCount + 4'(q_live[i]);
  end

  // Scan oldest to youngest so the last match found is the youngest.
  always_comb begin
    fwdHit  = 1'b0;
    fwdData = 32'd0;
    idx     = '0;
    if (fwdReg != 5'd0) begin
      if (_regWrite && (writeReg == fwdReg)) begin
        fwdHit  = 1'b1;
        fwdData = writeData;
      end
      for (int i = 0; i < DEPTH; i++) begin
        idx = head + AW'(i);
        if (q_live[idx] && (q_reg[idx] == fwdReg)) begin
          fwdHit  = 1'b1;
          fwdData = q_data[idx];
        end
      end
    end
  end
endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: driver pushes expected writes, a negedge
// monitor pops and compares every register-file write.
module tb_wb_arbiter;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        aluValid = 1'b0;
  logic [4:0]  aluReg = 5'd0;
  logic [31:0] aluData = 32'd0;
  logic        lsuValid = 1'b0;
  logic [4:0]  lsuReg = 5'd0;
  logic [31:0] lsuData = 32'd0;
  logic        lsuReady;
  logic        _regWrite;
  logic [4:0]  writeReg;
  logic [31:0] writeData;
  logic [4:0]  fwdReg = 5'd0;
  logic        fwdHit;
  logic [31:0] fwdData;
  logic [3:0]  pendCount;

  int total = 0;
  int passed = 0;
  logic [36:0] exp_q[$];

  wb_arbiter #(.DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .aluValid(aluValid), .aluReg(aluReg), .aluData(aluData),
    .lsuValid(lsuValid), .lsuReg(lsuReg), .lsuData(lsuData),
    .lsuReady(lsuReady),
    ._regWrite(_regWrite), .writeReg(writeReg), .writeData(writeData),
    .fwdReg(fwdReg), .fwdHit(fwdHit), .fwdData(fwdData),
    .pendCount(pendCount)
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic expect_wr(input logic [4:0] r, input logic [31:0] d);
    exp_q.push_back({r, d});
  endtask

  // Driver: called #1 after a posedge; holds inputs across one posedge.
  task automatic step(input logic av, input logic [4:0] ar, input logic [31:0] ad,
                      input logic lv, input logic [4:0] lr, input logic [31:0] ld,
                      input logic chk_ready, input logic exp_ready);
    aluValid = av; aluReg = ar; aluData = ad;
    lsuValid = lv; lsuReg = lr; lsuData = ld;
    @(negedge clk);
    if (chk_ready) check("lsuReady", 64'(lsuReady), 64'(exp_ready));
    @(posedge clk);
    #1;
    aluValid = 1'b0; lsuValid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
  endtask

  initial begin
    fork
      // Scoreboard monitor
      forever begin
        @(negedge clk);
        if (_regWrite) begin
          if (exp_q.size() == 0) begin
            total++;
            $display("FAIL unexpected_write: got reg %0d data 0x%0h, required no write at %0t",
                     writeReg, writeData, $time);
          end else begin
            check("write", 64'({writeReg, writeData}), 64'(exp_q.pop_front()));
          end
        end
      end
    join_none

    fwdReg = 5'd5;
    repeat (2) @(posedge clk);
    #1;
    check("rst_regWrite", 64'(_regWrite), 64'd0);
    check("rst_writeReg", 64'(writeReg), 64'd0);
    check("rst_writeData", 64'(writeData), 64'd0);
    check("rst_pendCount", 64'(pendCount), 64'd0);
    check("rst_lsuReady", 64'(lsuReady), 64'd1);
    check("rst_fwdHit", 64'(fwdHit), 64'd0);
    rst_n = 1'b1;
    fwdReg = 5'd0;

    // Single ALU write, exactly one cycle of _regWrite
    expect_wr(5'd5, 32'h11);
    step(1'b1, 5'd5, 32'h11, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
    idle(2);

    // ALU busy 5 cycles, LSU fills queue and is refused on the 5th
    for (int i = 0; i < 5; i++) begin
      expect_wr(5'(10 + i), 32'h100 + 32'(i));
      step(1'b1, 5'(10 + i), 32'h100 + 32'(i), 1'b1, 5'(1 + i), 32'h200 + 32'(i), 1'b1, (i < 4));
    end
    check("fill_pendCount", 64'(pendCount), 64'd4);
    for (int i = 0; i < 4; i++) expect_wr(5'(1 + i), 32'h200 + 32'(i));
    idle(4);
    check("drain_pendCount", 64'(pendCount), 64'd0);
    idle(1);

    // ALU kills a queued entry for the same register
    expect_wr(5'd3, 32'h33);
    step(1'b1, 5'd3, 32'h33, 1'b1, 5'd7, 32'hAA, 1'b1, 1'b1);
    check("kill_pend_before", 64'(pendCount), 64'd1);
    fwdReg = 5'd7;
    #1;
    check("kill_fwd_queued", 64'({fwdHit, fwdData}), 64'({1'b1, 32'hAA}));
    expect_wr(5'd7, 32'hBB);
    step(1'b1, 5'd7, 32'hBB, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
    check("kill_pend_after", 64'(pendCount), 64'd0);
    check("kill_fwd_output", 64'({fwdHit, fwdData}), 64'({1'b1, 32'hBB}));
    fwdReg = 5'd0;
    idle(3);

    // Forwarding returns the youngest of two entries for reg 9
    expect_wr(5'd3, 32'h1);
    step(1'b1, 5'd3, 32'h1, 1'b1, 5'd9, 32'h1, 1'b1, 1'b1);
    expect_wr(5'd4, 32'h2);
    step(1'b1, 5'd4, 32'h2, 1'b1, 5'd9, 32'h2, 1'b1, 1'b1);
    fwdReg = 5'd9;
    #1;
    check("fwd_youngest", 64'({fwdHit, fwdData}), 64'({1'b1, 32'h2}));
    fwdReg = 5'd8;
    #1;
    check("fwd_miss", 64'(fwdHit), 64'd0);
    fwdReg = 5'd0;
    #1;
    check("fwd_reg0", 64'(fwdHit), 64'd0);
    expect_wr(5'd9, 32'h1);
    expect_wr(5'd9, 32'h2);
    idle(3);

    // Register 0 drops; same-register collision keeps only the ALU
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h55, 1'b1, 1'b1);
    check("r0_lsu_pend", 64'(pendCount), 64'd0);
    step(1'b1, 5'd0, 32'h66, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
    expect_wr(5'd12, 32'h88);
    step(1'b1, 5'd0, 32'h77, 1'b1, 5'd12, 32'h88, 1'b1, 1'b1);
    check("r0_alu_pend", 64'(pendCount), 64'd0);
    expect_wr(5'd8, 32'h99);
    step(1'b1, 5'd8, 32'h99, 1'b1, 5'd8, 32'h98, 1'b1, 1'b1);
    check("collide_pend", 64'(pendCount), 64'd0);
    idle(2);

    // Full queue: push and pop in the same cycle
    for (int i = 0; i < 4; i++) begin
      expect_wr(5'(20 + i), 32'h300 + 32'(i));
      step(1'b1, 5'(20 + i), 32'h300 + 32'(i), 1'b1, 5'(1 + i), 32'h400 + 32'(i), 1'b1, 1'b1);
    end
    check("full_pend", 64'(pendCount), 64'd4);
    for (int i = 0; i < 5; i++) expect_wr(5'(1 + i), 32'h400 + 32'(i));
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'h404, 1'b1, 1'b1);
    check("pushpop_pend", 64'(pendCount), 64'd4);
    idle(5);
    check("pushpop_drained", 64'(pendCount), 64'd0);

    // Reset mid-operation with 3 pending; the last ALU write is discarded too
    for (int i = 0; i < 3; i++) begin
      if (i < 2) expect_wr(5'(20 + i), 32'h500 + 32'(i));
      step(1'b1, 5'(20 + i), 32'h500 + 32'(i), 1'b1, 5'(1 + i), 32'h600 + 32'(i), 1'b1, 1'b1);
    end
    check("prereset_pend", 64'(pendCount), 64'd3);
    fwdReg = 5'd1;
    #1;
    check("prereset_fwd", 64'(fwdHit), 64'd1);
    rst_n = 1'b0;
    #1;
    check("midrst_regWrite", 64'(_regWrite), 64'd0);
    check("midrst_writeReg", 64'(writeReg), 64'd0);
    check("midrst_writeData", 64'(writeData), 64'd0);
    check("midrst_pend", 64'(pendCount), 64'd0);
    check("midrst_lsuReady", 64'(lsuReady), 64'd1);
    check("midrst_fwdHit", 64'(fwdHit), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    fwdReg = 5'd0;
    idle(6);
    check("postrst_pend", 64'(pendCount), 64'd0);

    check("exp_q_empty", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 SHALL have parameter DEPTH, default 4, LSU pending-queue entry count (power of two, 2..8).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on posedge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port aluValid  input  1  ALU writeback request this cycle (never stalled).
REQ-005 SHALL have port aluReg  input  5  ALU destination register.
REQ-006 SHALL have port aluData  input  32  ALU result.
REQ-007 SHALL have port lsuValid  input  1  load/multi-cycle writeback request.
REQ-008 SHALL have port lsuReg  input  5  LSU destination register.
REQ-009 SHALL have port lsuData  input  32  LSU result.
REQ-010 SHALL have port lsuReady  output  1  queue can accept an LSU request this cycle.
REQ-011 SHALL have port _regWrite  output  1  register-file write enable.
REQ-012 SHALL have port writeReg  output  5  register-file write address.
REQ-013 SHALL have port writeData  output  32  register-file write data.
REQ-014 SHALL have port fwdReg  input  5  forwarding lookup address.
REQ-015 SHALL have port fwdHit  output  1  a pending (not yet committed) write to fwdReg exists.
REQ-016 SHALL have port fwdData  output  32  data of the youngest pending write to fwdReg.
REQ-017 SHALL have port pendCount  output  4  live entries in the LSU queue.

Function
REQ-018 SHALL register _regWrite/writeReg/writeData on posedge; the register file captures them on the following negedge.
REQ-019 SHALL accept an LSU request at a posedge only when lsuValid && lsuReady; lsuReady = (entries < DEPTH) || (a pop occurs this cycle).
REQ-020 SHALL, each posedge, select the output write by priority: (1) ALU request, (2) live queue head, (3) LSU request bypassing an empty queue; else _regWrite=0.
REQ-021 SHALL give ALU->port latency of exactly 1 cycle (request at posedge N, _regWrite high from N to N+1).
REQ-022 SHALL push an accepted LSU request into the queue when it is not selected in the same cycle; FIFO order, wrap-around pointers.
REQ-023 SHALL drop any request whose destination is register 0 (no queue entry, no port write, no forwarding hit).
REQ-024 SHALL, when an ALU request targets register R, kill every queue entry targeting R (ALU result is younger).
REQ-025 SHALL, when ALU and an accepted LSU request target the same R in one cycle, treat the LSU as older: LSU request is dropped, ALU writes.
REQ-026 SHALL discard a killed head entry on pop without asserting _regWrite; the cycle is consumed.
REQ-027 SHALL decrement pendCount on kill; a killed entry frees its slot only when popped.
REQ-028 SHALL compute fwdHit/fwdData combinationally: youngest live queue entry matching fwdReg, else registered output write if _regWrite && writeReg==fwdReg; fwdReg==0 never hits.
REQ-029 SHALL support simultaneous push and pop when full; lsuReady stays high that cycle.

Reset
REQ-030 SHALL, on rst_n low, asynchronously clear _regWrite=0, writeReg=0, writeData=0, all queue entries invalid, pointers 0, pendCount=0.
REQ-031 SHALL hold lsuReady=1 and fwdHit=0 during and immediately after reset; reset mid-operation discards all pending writes.

Verification
REQ-032 SHALL pass: aluValid, aluReg=5, aluData=0x11 at posedge 1 -> _regWrite=1, writeReg=5, writeData=0x11 during cycle 1-2 only.
REQ-033 SHALL pass: aluValid for 5 consecutive cycles plus lsuValid each cycle (regs 1..5) -> 4 accepted, lsuReady=0 on 5th, pendCount=4; then queue drains in order 1,2,3,4.
REQ-034 SHALL pass: queue holds reg 7=0xAA, ALU writes reg 7=0xBB -> reg 7 written 0xBB once; head pop of killed entry produces no write.
REQ-035 SHALL pass: queue holds reg 9 entries 0x1 then 0x2, fwdReg=9 -> fwdHit=1, fwdData=0x2.
REQ-036 SHALL pass: lsuValid with lsuReg=0 or aluReg=0 -> no _regWrite, pendCount unchanged.
REQ-037 SHALL pass: rst_n pulled low with pendCount=3 -> all outputs cleared immediately, no further writes after release.
